// File: rtl/sbox_pkg.sv
// Shared types and constants for the serialised PRESENT substitution layer.
package sbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int NIBBLES = 16;
  localparam int STATE_W = 64;

  // Plain-vector aliases so FSM registers stay as logic for older tools.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

endpackage

// File: rtl/sbox_table.sv
// Combinational 4-bit PRESENT S-box.
module sbox_table
  import sbox_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  always_comb begin
    case (nibble_i)
      4'h0: nibble_o = 4'hC;
      4'h1: nibble_o = 4'h5;
      4'h2: nibble_o = 4'h6;
      4'h3: nibble_o = 4'hB;
      4'h4: nibble_o = 4'h9;
      4'h5: nibble_o = 4'h0;
      4'h6: nibble_o = 4'hA;
      4'h7: nibble_o = 4'hD;
      4'h8: nibble_o = 4'h3;
      4'h9: nibble_o = 4'hE;
      4'hA: nibble_o = 4'hF;
      4'hB: nibble_o = 4'h8;
      4'hC: nibble_o = 4'h4;
      4'hD: nibble_o = 4'h7;
      4'hE: nibble_o = 4'h1;
      default: nibble_o = 4'h2;
    endcase
  end

endmodule

// File: rtl/sbox_layer_sched.sv
// Applies the PRESENT S-box layer to a 64-bit word, NUM_SBOX nibbles per cycle,
// LSB group first, between a valid/ready input and a valid/ready output.
module sbox_layer_sched
  import sbox_pkg::*;
#(
  parameter int STATE_W  = 64,
  parameter int NUM_SBOX = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int N     = NIBBLES / NUM_SBOX;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (STATE_W != 64) begin : g_bad_state_w
    $error("sbox_layer_sched: STATE_W must be 64");
  end
  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("sbox_layer_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [3:0]         sboxIn  [NUM_SBOX];
  logic [3:0]         sboxOut [NUM_SBOX];
  int                 groupBase;

  // Index of the first nibble handled in the current RUN cycle.
  assign groupBase = int'(cnt_q) * NUM_SBOX;

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    assign sboxIn[g] = data_q[4*(groupBase + g) +: 4];
    sbox_table u_sbox (
      .nibble_i (sboxIn[g]),
      .nibble_o (sboxOut[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int g = 0; g < NUM_SBOX; g++) begin
          data_d[4*(groupBase + g) +: 4] = sboxOut[g];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // in_ready is gated by rst so it reads low while reset is held.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer_sched.sv
// Randomised self-checking bench for sbox_layer_sched at NUM_SBOX = 1, 4 and 16,
// compared against a nibble-lookup reference model.
module tb_sbox_layer_sched;

  localparam int NCFG = 3;

  logic            clk;
  logic [NCFG-1:0] rst;
  logic [NCFG-1:0] inValid;
  logic [NCFG-1:0] inReady;
  logic [NCFG-1:0] outValid;
  logic [NCFG-1:0] outReady;
  logic [NCFG-1:0] busy;
  logic [63:0]     inData  [NCFG];
  logic [63:0]     outData [NCFG];

  int checks = 0;
  int errors = 0;
  int curNs  = 0;

  int         nsbTab  [NCFG] = '{1, 4, 16};
  logic [3:0] sboxMap [16]   = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NS = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    sbox_layer_sched #(
      .STATE_W  (64),
      .NUM_SBOX (NS)
    ) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .in_data   (inData[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .out_data  (outData[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] golden(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sboxMap[w[4*i +: 4]];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s (NUM_SBOX=%0d): got %h, expected %h",
               tag, curNs, observed, expected);
    end
  endtask

  task automatic resetDut(input int k);
    rst[k] = 1'b1;
    #1;
    checkOutput("resetInReady",  64'(inReady[k]),  64'd0);
    checkOutput("resetOutValid", 64'(outValid[k]), 64'd0);
    checkOutput("resetBusy",     64'(busy[k]),     64'd0);
    checkOutput("resetOutData",  outData[k],       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst[k] = 1'b0;
    #1;
    checkOutput("readyAfterRelease", 64'(inReady[k]), 64'd1);
    @(negedge clk);
  endtask

  // Entered and left on a falling edge with inValid and outReady low.
  task automatic applyStimulus(input int k, input logic [63:0] word,
                               input logic [63:0] expected, input int holdCycles,
                               input bit flood);
    int n;
    int lat;
    n   = 16 / nsbTab[k];
    lat = 0;
    checkOutput("readyBeforeAccept", 64'(inReady[k]), 64'd1);
    inValid[k] = 1'b1;
    inData[k]  = word;
    @(posedge clk);
    @(negedge clk);
    if (!flood) inValid[k] = 1'b0;
    checkOutput("busyInRun", 64'(busy[k]), 64'd1);
    while (outValid[k] !== 1'b1 && lat < 100) begin
      if (flood) begin
        inData[k] = {$urandom(), $urandom()};
        checkOutput("readyLowInRun", 64'(inReady[k]), 64'd0);
      end
      lat++;
      @(negedge clk);
    end
    inValid[k] = 1'b0;
    checkOutput("latency", 64'(lat), 64'(n));
    for (int h = 0; h < holdCycles; h++) begin
      checkOutput("holdValid",    64'(outValid[k]), 64'd1);
      checkOutput("holdData",     outData[k],       expected);
      checkOutput("holdReadyLow", 64'(inReady[k]),  64'd0);
      @(negedge clk);
    end
    checkOutput("result", outData[k], expected);
    outReady[k] = 1'b1;
    @(negedge clk);
    outReady[k] = 1'b0;
    checkOutput("validOneCycle",       64'(outValid[k]), 64'd0);
    checkOutput("readyAfterHandshake", 64'(inReady[k]),  64'd1);
  endtask

  task automatic midRunReset(input int k);
    int n;
    n = 16 / nsbTab[k];
    inValid[k] = 1'b1;
    inData[k]  = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    inValid[k] = 1'b0;
    for (int i = 0; i < n / 2; i++) @(negedge clk);
    checkOutput("busyBeforeReset", 64'(busy[k]), 64'd1);
    rst[k] = 1'b1;
    #1;
    checkOutput("midResetOutValid", 64'(outValid[k]), 64'd0);
    checkOutput("midResetBusy",     64'(busy[k]),     64'd0);
    checkOutput("midResetOutData",  outData[k],       64'd0);
    checkOutput("midResetInReady",  64'(inReady[k]),  64'd0);
    @(negedge clk);
    rst[k] = 1'b0;
    #1;
    checkOutput("midResetReadyAfter", 64'(inReady[k]), 64'd1);
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      checkOutput("noEmitAfterReset", 64'(outValid[k]), 64'd0);
    end
  endtask

  task automatic backToBack(input int k);
    logic [63:0] words [8];
    logic [63:0] expQ [$];
    int n;
    int sent;
    int got;
    int lastOut;
    int cycle;
    bit pending;
    n       = 16 / nsbTab[k];
    sent    = 0;
    got     = 0;
    lastOut = -1;
    cycle   = 0;
    pending = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = {$urandom(), $urandom()};
    outReady[k] = 1'b1;
    inValid[k]  = 1'b1;
    inData[k]   = words[0];
    while (got < 8 && cycle < 400) begin
      if (pending) begin
        pending = 1'b0;
        if (sent < 8) inData[k] = words[sent];
        else inValid[k] = 1'b0;
      end
      if (outValid[k] === 1'b1) begin
        if (expQ.size() == 0) checkOutput("b2bSpurious", 64'(outValid[k]), 64'd0);
        else checkOutput("b2bData", outData[k], expQ.pop_front());
        if (lastOut >= 0) checkOutput("b2bSpacing", 64'(cycle - lastOut), 64'(n + 2));
        lastOut = cycle;
        got++;
      end
      if (inValid[k] && inReady[k]) begin
        expQ.push_back(golden(inData[k]));
        sent++;
        pending = 1'b1;
      end
      @(negedge clk);
      cycle++;
    end
    inValid[k]  = 1'b0;
    outReady[k] = 1'b0;
    checkOutput("b2bCount",    64'(got),         64'd8);
    checkOutput("b2bLeftover", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    rst      = '0;
    inValid  = '0;
    outReady = '0;
    for (int k = 0; k < NCFG; k++) inData[k] = '0;
    #2;
    rst = '1;
    for (int k = 0; k < NCFG; k++) begin
      curNs = nsbTab[k];
      resetDut(k);
      applyStimulus(k, 64'h0000_0000_0000_0000, 64'hCCCC_CCCC_CCCC_CCCC, 0, 1'b0);
      applyStimulus(k, 64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 1, 1'b0);
      applyStimulus(k, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2222_2222_2222_2222, 0, 1'b0);
      w = {$urandom(), $urandom()};
      applyStimulus(k, w, golden(w), 10, 1'b0);
      w = {$urandom(), $urandom()};
      applyStimulus(k, w, golden(w), 2, 1'b1);
      midRunReset(k);
      applyStimulus(k, 64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 0, 1'b0);
      backToBack(k);
      for (int r = 0; r < 3; r++) begin
        w = {$urandom(), $urandom()};
        applyStimulus(k, w, golden(w), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
